ps2_key_decoder: RTL

- Sits directly downstream of the PS2 serial receiver; consumes its assembled scan-code byte and the code-ready level.
- Interprets set-2 prefixes (E0 extended, F0 break), tracks left/right shift state, and translates make codes for letters, digits, space, enter and backspace into 8-bit ASCII.
- Buffers translated characters in a small FIFO read by the consumer (display or UART stage) through a pop strobe.

---
 rtl/ps2_key_pkg.sv | 78 +++++++
 rtl/ps2_char_fifo.sv | 58 +++++
 rtl/ps2_key_decoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/ps2_key_pkg.sv
// Shared types, scan-code constants and the set-2 to ASCII translation
// used by the PS/2 key decoder and its character FIFO.
package ps2_key_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BREAK,
        S_EXT_BREAK
    } state_t;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Returns {hit, ascii}; hit=0 means the code has no character.
    function automatic logic [8:0] ps2_translate(
        input logic [7:0] code,
        input logic       shift
    );
        logic [7:0] lc;
        logic [8:0] res;
        lc  = 8'h00;
        res = 9'h000;
        case (code)
            8'h1C: lc = 8'h61;
            8'h32: lc = 8'h62;
            8'h21: lc = 8'h63;
            8'h23: lc = 8'h64;
            8'h24: lc = 8'h65;
            8'h2B: lc = 8'h66;
            8'h34: lc = 8'h67;
            8'h33: lc = 8'h68;
            8'h43: lc = 8'h69;
            8'h3B: lc = 8'h6A;
            8'h42: lc = 8'h6B;
            8'h4B: lc = 8'h6C;
            8'h3A: lc = 8'h6D;
            8'h31: lc = 8'h6E;
            8'h44: lc = 8'h6F;
            8'h4D: lc = 8'h70;
            8'h15: lc = 8'h71;
            8'h2D: lc = 8'h72;
            8'h1B: lc = 8'h73;
            8'h2C: lc = 8'h74;
            8'h3C: lc = 8'h75;
            8'h2A: lc = 8'h76;
            8'h1D: lc = 8'h77;
            8'h22: lc = 8'h78;
            8'h35: lc = 8'h79;
            8'h1A: lc = 8'h7A;
            default: lc = 8'h00;
        endcase
        case (code)
            8'h45: res = {1'b1, 8'h30};
            8'h16: res = {1'b1, 8'h31};
            8'h1E: res = {1'b1, 8'h32};
            8'h26: res = {1'b1, 8'h33};
            8'h25: res = {1'b1, 8'h34};
            8'h2E: res = {1'b1, 8'h35};
            8'h36: res = {1'b1, 8'h36};
            8'h3D: res = {1'b1, 8'h37};
            8'h3E: res = {1'b1, 8'h38};
            8'h46: res = {1'b1, 8'h39};
            8'h29: res = {1'b1, 8'h20};
            8'h5A: res = {1'b1, 8'h0D};
            8'h66: res = {1'b1, 8'h08};
            default: res = 9'h000;
        endcase
        // Letters are stored lowercase; shift maps to the 0x41.. block.
        if (lc != 8'h00) begin
            res = {1'b1, shift ? (lc - 8'h20) : lc};
        end
        return res;
    endfunction

endpackage

// File: rtl/ps2_char_fifo.sv
// Synchronous character FIFO with registered count and wrapping pointers.
// Ports: i_clk, i_rst, i_push/i_data, i_pop, o_valid, o_data, o_count, o_full.
module ps2_char_fifo #(
    parameter int FIFO_DEPTH = 8,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [7:0]    i_data,
    input  logic          i_pop,
    output logic          o_valid,
    output logic [7:0]    o_data,
    output logic [AW:0]   o_count,
    output logic          o_full
);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_empty;
    logic          w_do_pop;
    logic          w_do_push;

    assign w_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = ~w_empty;
    assign o_data  = w_empty ? 8'h00 : r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: prefix FSM, shift tracking, ASCII FIFO.
// Ports: Clock_50, Reset, PS2_code/_ready in; char_* FIFO, shift, overflow out.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic               Clock_50,
    input  logic               Reset,
    input  logic [7:0]         PS2_code,
    input  logic               PS2_code_ready,
    input  logic               char_pop,
    input  logic               clear_overflow,
    output logic               char_valid,
    output logic [7:0]         char_data,
    output logic [FIFO_AW:0]   char_count,
    output logic               shift_active,
    output logic               overflow
);

    state_t     r_state;
    logic       r_ready_prev;
    logic       r_lshift;
    logic       r_rshift;
    logic       r_push;
    logic [7:0] r_push_data;
    logic       r_overflow;
    logic       w_event;
    logic [8:0] w_xlat;
    logic       w_full;
    logic       w_drop;

    assign w_event = PS2_code_ready & ~r_ready_prev;
    assign w_xlat  = ps2_translate(PS2_code, r_lshift | r_rshift);

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            // Preset high so a ready already asserted at release is ignored.
            r_ready_prev <= 1'b1;
            r_lshift     <= 1'b0;
            r_rshift     <= 1'b0;
            r_push       <= 1'b0;
            r_push_data  <= 8'h00;
        end else begin
            r_ready_prev <= PS2_code_ready;
            r_push       <= 1'b0;
            if (w_event) begin
                case (r_state)
                    S_IDLE: begin
                        if (PS2_code == SC_EXT) begin
                            r_state <= S_EXT;
                        end else if (PS2_code == SC_BREAK) begin
                            r_state <= S_BREAK;
                        end else if (PS2_code == SC_LSHIFT) begin
                            r_lshift <= 1'b1;
                        end else if (PS2_code == SC_RSHIFT) begin
                            r_rshift <= 1'b1;
                        end else begin
                            r_push      <= w_xlat[8];
                            r_push_data <= w_xlat[7:0];
                        end
                    end
                    S_EXT: begin
                        if (PS2_code == SC_BREAK) begin
                            r_state <= S_EXT_BREAK;
                        end else if (PS2_code != SC_EXT) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_BREAK: begin
                        if (PS2_code == SC_LSHIFT) r_lshift <= 1'b0;
                        if (PS2_code == SC_RSHIFT) r_rshift <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // A full FIFO with a concurrent pop still takes the push.
    assign w_drop = r_push & w_full & ~char_pop;

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    ps2_char_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (Clock_50),
        .i_rst   (Reset),
        .i_push  (r_push),
        .i_data  (r_push_data),
        .i_pop   (char_pop),
        .o_valid (char_valid),
        .o_data  (char_data),
        .o_count (char_count),
        .o_full  (w_full)
    );

    assign shift_active = r_lshift | r_rshift;
    assign overflow     = r_overflow;

endmodule
